bcd_pulse_counter: RTL
======================

# bcd_pulse_counter

Front-end stage of the seven-segment counter display. Synchronises the raw asynchronous `data` pin and debounces it. Counts its rising edges as a three-digit packed BCD value, 000–999. Drives the 12-bit `data_bcd` bus that the display multiplexer scans out digit by digit.

## Interface
Parameters:
- `DB_CYCLES`, default 1000000. Consecutive stable clock cycles required to accept a level change (10 ms at 100 MHz). Legal range 1 to 2^24−1.

Ports:
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `data`  in  1  raw asynchronous pulse input, e.g. a push-button.
- `clear`  in  1  synchronous count clear, active-high, single-cycle or held.
- `data_bcd`  out  12  packed BCD count, registered: [11:8] hundreds, [7:4] tens, [3:0] units.
- `pulse`  out  1  one-cycle strobe, high in the cycle `data_bcd` shows a newly incremented value.
- `ovf`  out  1  sticky wrap flag.

## Operation
- Reset values, applied while `reset_n`=0 at a rising edge:
  - `data_bcd`=12'h000, `pulse`=0, `ovf`=0.
  - Synchroniser flops = 0.
  - FSM = LOW.
  - Debounce counter = 0.
- Synchroniser: two flops, `data` → `s1` → `s2`. Only `s2` is used downstream.
- Debounce FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW.
  - LOW: if `s2`=1, load counter with 1 and go to WAIT_HIGH.
  - WAIT_HIGH: if `s2`=0, return to LOW; the counter is don't-care. Otherwise increment the counter; when it reaches `DB_CYCLES`, go to HIGH and assert the internal `rise`.
  - HIGH and WAIT_LOW: mirror image of the above. Reaching `DB_CYCLES` in WAIT_LOW goes to LOW with no event.
  - Glitches shorter than `DB_CYCLES` cycles produce no count.
- BCD increment on `rise`:
  - Units +1. Units 9→0 carries to tens; tens 9→0 carries to hundreds.
  - 999→000 wraps and sets `ovf`=1.
  - No digit ever holds a value above 9.
- `clear`=1 at an edge: `data_bcd`←000, `ovf`←0, `pulse`←0. This applies even when `rise` is asserted in the same cycle: clear wins and that edge is lost. The FSM is not affected by `clear`.
- `pulse` = registered copy of (`rise` & ~`clear`). It is coincident with the updated `data_bcd`.
- A falling edge never changes the count.

## Timing
- `data` goes high before edge E1 and stays stable:
  - `s2`=1 after E2.
  - FSM enters WAIT_HIGH at E3 and HIGH at E(3+`DB_CYCLES`).
  - `data_bcd` and `pulse` update at E(4+`DB_CYCLES`), with `DEBOUNCE_EN` defined.
- Counts at most one per debounced high period. Maximum count rate is one per 2·`DB_CYCLES`+2 cycles.
- `reset_n` low mid-debounce aborts the pending count; no event is generated after release, even if `data` is still high.
- `reset_n` takes priority over `clear`.

## Configuration
- `BCD_PULSE_DEBOUNCE_EN` defined: FSM and debounce counter as above.
- `BCD_PULSE_DEBOUNCE_EN` undefined:
  - FSM and counter are removed and `DB_CYCLES` is ignored.
  - `rise` = `s2` & ~`s3`, where `s3` is one extra flop after `s2`.
  - `data_bcd` and `pulse` update at E4.
  - Every synchronised rising edge counts, glitches included.

## Structure
- Shared package `bcd_pkg`:
  - `BCD_DIGITS`=3.
  - Debounce FSM state typedef (2-bit encoding).
  - Function `bcd_digit_inc(digit, carry_in)` returning {carry_out, digit}.
- Sub-module `bcd_debouncer`: synchroniser plus FSM, output `rise`; compiled away to the edge detector when the macro is absent.
- The top instantiates `bcd_debouncer` and holds the three digit registers plus `ovf` and `pulse`.

## Test plan
Unless noted, benches use `DB_CYCLES`=4 with `BCD_PULSE_DEBOUNCE_EN` defined.
- Reset: `reset_n`=0 for 3 cycles with `data`=1 → `data_bcd`=000, `pulse`=0, `ovf`=0; no count after release until `data` falls and rises again.
- Single clean pulse: `data` high for 20 cycles → exactly one `pulse`, at E8 after the rise; `data_bcd`=001.
- Glitches: 3-cycle high glitch, then 1-cycle high glitch → `data_bcd` stays 000 and no `pulse`. Macro undefined, same stimulus → `data_bcd`=002.
- Carry chain: 9 pulses → 009; 10th pulse → 010; preload with 99 pulses then one more → 100.
- Wrap: 1000 pulses → `data_bcd`=000, `ovf`=1. A further pulse → 001, `ovf` still 1.
- Clear collision: `clear`=1 in the same cycle as `rise` with count 057 → `data_bcd`=000, `ovf`=0, no `pulse`. Next pulse → 001.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD pulse counter: digit count, debounce
// FSM encoding and the single-digit BCD incrementer.
package bcd_pkg;

    localparam int BCD_DIGITS = 3;
    localparam int DB_CNT_W   = 24;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } db_state_e;

    // Returns {carry_out, digit}; any code at or above 9 rolls to 0 so a digit can never exceed 9.
    function automatic logic [4:0] bcd_digit_inc(input bcd_digit_t digit, input logic carry_in);
        if (!carry_in) begin
            return {1'b0, digit};
        end
        if (digit >= 4'd9) begin
            return {1'b1, 4'd0};
        end
        return {1'b0, digit + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_debouncer.sv
// Two-flop synchroniser plus debounce FSM producing a one-cycle registered
// `rise`. Without BCD_PULSE_DEBOUNCE_EN it reduces to a synchronised edge detector.
module bcd_debouncer
    import bcd_pkg::*;
#(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic data,
    output logic rise
);

    if (DB_CYCLES < 1 || DB_CYCLES > (1 << DB_CNT_W) - 1) begin : g_bad_db_cycles
        $error("bcd_debouncer: DB_CYCLES out of range");
    end

    logic       s1;
    logic       s2;
    logic [1:0] fill;
    logic       armed;
    logic       rise_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= data;
            s2 <= s1;
        end
    end

    // Events are suppressed until s2 has been seen low after reset, so a level
    // already high when reset releases never counts as an edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fill  <= 2'd0;
            armed <= 1'b0;
        end else if (fill != 2'd2) begin
            fill <= fill + 2'd1;
        end else if (!s2) begin
            armed <= 1'b1;
        end
    end

`ifdef BCD_PULSE_DEBOUNCE_EN
    localparam logic [DB_CNT_W-1:0] DB_LIMIT = DB_CNT_W'(DB_CYCLES);

    db_state_e             state;
    db_state_e             state_nx;
    logic [DB_CNT_W-1:0]   cnt;
    logic [DB_CNT_W-1:0]   cnt_nx;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_LOW;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rise_d   = 1'b0;
        case (state)
            ST_LOW: begin
                if (s2) begin
                    cnt_nx   = DB_CNT_W'(1);
                    state_nx = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (!s2) begin
                    state_nx = ST_LOW;
                end else if (cnt == DB_LIMIT) begin
                    state_nx = ST_HIGH;
                    rise_d   = armed;
                end else begin
                    cnt_nx = cnt + DB_CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!s2) begin
                    cnt_nx   = DB_CNT_W'(1);
                    state_nx = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                if (s2) begin
                    state_nx = ST_HIGH;
                end else if (cnt == DB_LIMIT) begin
                    state_nx = ST_LOW;
                end else begin
                    cnt_nx = cnt + DB_CNT_W'(1);
                end
            end
            default: state_nx = ST_LOW;
        endcase
    end
`else
    logic s3;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s3 <= 1'b0;
        end else begin
            s3 <= s2;
        end
    end

    always_comb begin
        rise_d = armed & s2 & ~s3;
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rise <= 1'b0;
        end else begin
            rise <= rise_d;
        end
    end

endmodule

// File: rtl/bcd_pulse_counter.sv
// Debounced rising-edge counter with a three-digit packed BCD output and sticky
// wrap flag. Debouncing is enabled by defining BCD_PULSE_DEBOUNCE_EN.
module bcd_pulse_counter
    import bcd_pkg::*;
#(
    parameter int DB_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        data,
    input  logic        clear,
    output logic [11:0] data_bcd,
    output logic        pulse,
    output logic        ovf
);

    logic                          rise;
    bcd_digit_t [BCD_DIGITS-1:0]   digits;
    bcd_digit_t [BCD_DIGITS-1:0]   digits_nx;
    logic       [BCD_DIGITS:0]     carry;

    bcd_debouncer #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debouncer (
        .clock   (clock),
        .reset_n (reset_n),
        .data    (data),
        .rise    (rise)
    );

    // Ripple the increment from units upward; carry[BCD_DIGITS] marks 999 -> 000.
    always_comb begin
        carry     = '0;
        digits_nx = digits;
        carry[0]  = rise;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            {carry[i+1], digits_nx[i]} = bcd_digit_inc(digits[i], carry[i]);
        end
    end

    // Clear outranks a coincident rise: that edge is dropped, not deferred.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            digits <= '0;
            ovf    <= 1'b0;
            pulse  <= 1'b0;
        end else if (clear) begin
            digits <= '0;
            ovf    <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            pulse <= rise;
            if (rise) begin
                digits <= digits_nx;
                if (carry[BCD_DIGITS]) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    assign data_bcd = digits;

endmodule
